// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 16:1 mux through all channels, settling then sampling each, into one 16-bit word.
// Define MUX_SCAN_PARITY_EN to add a registered parity output over each completed word.
module mux_scan_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [3:0]  sel,
    output logic        mux_en_n,
    input  logic        mux_v,
    output logic [15:0] data_out,
    output logic        data_valid,
    input  logic        data_ready,
`ifdef MUX_SCAN_PARITY_EN
    output logic        parity,
`endif
    output logic        busy
);
    localparam logic [3:0] SC = 4'(SETTLE_CYCLES);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, HOLD} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] shadow;
    logic [15:0] captured;
    logic        launch;
    // A new scan may begin from IDLE, or from HOLD only in the cycle the pending word is consumed.
    assign launch = start && (state == IDLE || (state == HOLD && data_ready));
    always_comb begin
        captured = shadow;
        captured[sel] = mux_v;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shadow     <= '0;
            sel        <= '0;
            mux_en_n   <= 1'b1;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            parity     <= 1'b0;
`endif
        end else if (abort && (state == SETTLE || state == SAMPLE)) begin
            state    <= IDLE;
            cnt      <= '0;
            shadow   <= '0;
            sel      <= '0;
            mux_en_n <= 1'b1;
            busy     <= 1'b0;
        end else if (launch) begin
            state      <= (SC == 4'd0) ? SAMPLE : SETTLE;
            cnt        <= SC;
            sel        <= '0;
            mux_en_n   <= 1'b0;
            busy       <= 1'b1;
            data_valid <= 1'b0;
        end else if (state == HOLD) begin
            if (data_ready) begin
                data_valid <= 1'b0;
                state      <= IDLE;
            end
        end else if (state == SETTLE) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= SAMPLE;
        end else if (state == SAMPLE) begin
            shadow <= captured;
            if (sel == 4'd15) begin
                data_out   <= captured;
                data_valid <= 1'b1;
                mux_en_n   <= 1'b1;
                sel        <= '0;
                busy       <= 1'b0;
                state      <= HOLD;
`ifdef MUX_SCAN_PARITY_EN
                parity     <= ^captured;
`endif
            end else begin
                sel   <= sel + 4'd1;
                cnt   <= SC;
                state <= (SC == 4'd0) ? SAMPLE : SETTLE;
            end
        end
    end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed plus randomized checks of two scanners (settle 2 and settle 0)
// against a pattern-driven mux model; expected word is simply the pattern the mux presents.
module tb_mux_scan_ctrl;
    logic clk = 0;
    logic rst, start, abort, ready, w;
    logic [15:0] pat;
    logic [3:0]  sel_a, sel_b, sel_o;
    logic        en_a, en_b, en_o, v_a, v_b, dv_a, dv_b, dv, busy_a, busy_b, busy_o;
    logic [15:0] dout_a, dout_b, dout_o;
    int          spc;
    int          vectors = 0;
    int          miscompares = 0;
`ifdef MUX_SCAN_PARITY_EN
    logic par_a, par_b, par_o;
    assign par_o = w ? par_b : par_a;
`endif

    always #5 clk = ~clk;

    // Mux model: enable high forces output high, otherwise presents pattern bit for the selected channel.
    assign v_a = en_a ? 1'b1 : pat[sel_a];
    assign v_b = en_b ? 1'b1 : pat[sel_b];
    assign sel_o  = w ? sel_b  : sel_a;
    assign en_o   = w ? en_b   : en_a;
    assign dv     = w ? dv_b   : dv_a;
    assign busy_o = w ? busy_b : busy_a;
    assign dout_o = w ? dout_b : dout_a;
    assign spc    = w ? 1 : 3;

    mux_scan_ctrl #(.SETTLE_CYCLES(2)) u_a (
        .clk(clk), .rst(rst), .start(w ? 1'b0 : start), .abort(w ? 1'b0 : abort),
        .sel(sel_a), .mux_en_n(en_a), .mux_v(v_a), .data_out(dout_a), .data_valid(dv_a),
        .data_ready(w ? 1'b0 : ready),
`ifdef MUX_SCAN_PARITY_EN
        .parity(par_a),
`endif
        .busy(busy_a));

    mux_scan_ctrl #(.SETTLE_CYCLES(0)) u_b (
        .clk(clk), .rst(rst), .start(w ? start : 1'b0), .abort(w ? abort : 1'b0),
        .sel(sel_b), .mux_en_n(en_b), .mux_v(v_b), .data_out(dout_b), .data_valid(dv_b),
        .data_ready(w ? ready : 1'b0),
`ifdef MUX_SCAN_PARITY_EN
        .parity(par_b),
`endif
        .busy(busy_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_sel"}, sel_o, 0);
        chk({tag, "_en_n"}, en_o, 1);
        chk({tag, "_data"}, dout_o, 0);
        chk({tag, "_valid"}, dv, 0);
        chk({tag, "_busy"}, busy_o, 0);
`ifdef MUX_SCAN_PARITY_EN
        chk({tag, "_parity"}, par_o, 0);
`endif
    endtask

    // Called at the negedge just after the edge that accepted start.
    task automatic wait_scan(input logic [15:0] p, input string tag);
        int n = 0;
        int bad = 0;
        while (n < 400 && dv !== 1'b1) begin
            if (sel_o !== 4'(n / spc) || busy_o !== 1'b1 || en_o !== 1'b0) bad++;
            start = 1'($urandom);
            @(negedge clk);
            n++;
        end
        start = 0;
        chk({tag, "_latency"}, n, 16 * spc);
        chk({tag, "_sel_seq"}, bad, 0);
        chk({tag, "_data"}, dout_o, p);
        chk({tag, "_done_busy"}, busy_o, 0);
        chk({tag, "_done_en_n"}, en_o, 1);
`ifdef MUX_SCAN_PARITY_EN
        chk({tag, "_parity"}, par_o, ^p);
`endif
    endtask

    task automatic start_scan(input logic [15:0] p, input string tag);
        pat = p;
        start = 1;
        @(negedge clk);
        wait_scan(p, tag);
    endtask

    task automatic consume(input string tag);
        ready = 1;
        @(negedge clk);
        ready = 0;
        chk({tag, "_xfer_valid"}, dv, 0);
        chk({tag, "_xfer_busy"}, busy_o, 0);
    endtask

    initial begin
        logic [15:0] p, p2;
        int bad, n, k;
        w = 0; rst = 0; start = 0; abort = 0; ready = 0; pat = 0;
        #12 rst = 1;
        #1 chk_idle_zero("por");
        @(negedge clk) rst = 0;
        @(negedge clk);

        // Basic scan with consumer always ready
        ready = 1;
        start_scan(16'hA5C3, "a5c3");
        @(negedge clk);
        ready = 0;
        chk("a5c3_xfer_valid", dv, 0);

        // Unconsumed result must survive start requests
        p = 16'($urandom);
        start_scan(p, "held");
        bad = 0;
        repeat (10) begin
            start = 1;
            @(negedge clk);
            if (dv !== 1'b1 || dout_o !== p || busy_o !== 1'b0) bad++;
        end
        chk("hold_stable", bad, 0);
        start = 0;
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("hold_abort_valid", dv, 1);

        // Consume and restart in the same cycle
        p2 = 16'($urandom);
        pat = p2;
        ready = 1;
        start = 1;
        @(negedge clk);
        ready = 0;
        chk("b2b_valid", dv, 0);
        chk("b2b_busy", busy_o, 1);
        wait_scan(p2, "b2b");
        consume("b2b");

        // Abort while on channel 7
        pat = 16'($urandom);
        start = 1;
        @(negedge clk);
        start = 0;
        n = 0;
        while (sel_o !== 4'd7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach7", sel_o, 7);
        abort = 1;
        start = 1;
        @(negedge clk);
        abort = 0;
        start = 0;
        chk("abort_busy", busy_o, 0);
        chk("abort_en_n", en_o, 1);
        chk("abort_sel", sel_o, 0);
        chk("abort_data", dout_o, p2);
        chk("abort_valid", dv, 0);
        repeat (3) @(negedge clk);
        chk("abort_stays_idle", busy_o, 0);

        // Asynchronous reset while settling channel 12
        pat = 16'($urandom);
        start = 1;
        @(negedge clk);
        start = 0;
        n = 0;
        while (sel_o !== 4'd12 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach12", sel_o, 12);
        #2 rst = 1;
        #1 chk_idle_zero("rst12");
        @(negedge clk) rst = 0;
        @(negedge clk);
        p = 16'($urandom);
        start_scan(p, "post_rst");
        consume("post_rst");

        // Random patterns with random consumer delay
        for (int i = 0; i < 4; i++) begin
            p = 16'($urandom);
            start_scan(p, "rand");
            k = $urandom_range(0, 5);
            repeat (k) @(negedge clk);
            chk("rand_held", dout_o, p);
            consume("rand");
        end

        // Zero settle instance
        w = 1;
        @(negedge clk);
        start_scan(16'hFFFE, "s0_fffe");
        consume("s0_fffe");
        p = 16'($urandom);
        start_scan(p, "s0_rand");

        // Reset while a result is held discards it
        #2 rst = 1;
        #1 chk_idle_zero("rst_hold");
        @(negedge clk) rst = 0;
        @(negedge clk);
        start_scan(16'h0001, "s0_after_rst");
        consume("s0_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
